alut_apb_master6: RTL and testbench

//  APB2 initiator that drives the ALUT register bank from a simple valid/ready request port.
//  - Issues single register reads/writes as two-cycle SETUP/ACCESS transfers (no pready).
//  - Returns read data on a response port with valid/ready backpressure.
//  - Optionally re-reads a register until masked bits clear (status polling).

---
 rtl/alut_apb_master6_pkg.sv | 19 +
 rtl/alut_apb_master_defines6.v | 9 +
 rtl/alut_poll_ctr6.sv | 50 +++++
 rtl/alut_apb_master6.sv | 193 +++++++++++++++++++
 tb/tb_alut_apb_master6.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alut_apb_master6_pkg.sv
// Types and helpers shared by the ALUT APB initiator and its poll counter.
`include "alut_apb_master_defines6.v"

package alut_apb_master6_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = `ALUT_ST_IDLE,
    ST_SETUP  = `ALUT_ST_SETUP,
    ST_ACCESS = `ALUT_ST_ACCESS,
    ST_WAIT   = `ALUT_ST_WAIT,
    ST_RESP   = `ALUT_ST_RESP
  } state_t;

  // The APB bus is owned only during SETUP and ACCESS.
  function automatic logic is_apb_state(input state_t st);
    return (st == ST_SETUP) || (st == ST_ACCESS);
  endfunction

endpackage

// File: rtl/alut_apb_master_defines6.v
// State encodings shared by the ALUT APB initiator.
`ifndef ALUT_APB_MASTER_DEFINES6_V
`define ALUT_APB_MASTER_DEFINES6_V
`define ALUT_ST_IDLE   3'd0
`define ALUT_ST_SETUP  3'd1
`define ALUT_ST_ACCESS 3'd2
`define ALUT_ST_WAIT   3'd3
`define ALUT_ST_RESP   3'd4
`endif

// File: rtl/alut_poll_ctr6.sv
// Poll read counter (saturating) and inter-read gap timer for alut_apb_master6.
module alut_poll_ctr6 #(
  parameter int POLL_MAX = 16,
  parameter int POLL_GAP = 2
) (
  input  logic pclk6,
  input  logic p_reset6,
  input  logic load,
  input  logic tick,
  input  logic gap_load,
  input  logic gap_tick,
  output logic gap_done,
  output logic exhausted
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

  logic [CNT_W-1:0] cnt_r;
  logic [GAP_W-1:0] gap_r;

  // Read counter and gap down-counter.
  always_ff @(posedge pclk6) begin
    if (p_reset6) begin
      cnt_r <= '0;
      gap_r <= '0;
    end else begin
      if (load) begin
        cnt_r <= '0;
      end else if (tick && (cnt_r != CNT_W'(POLL_MAX))) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (gap_load) begin
        gap_r <= GAP_INIT;
      end else if (gap_tick && (gap_r != '0)) begin
        gap_r <= gap_r - 1'b1;
      end else begin
        gap_r <= gap_r;
      end
    end
  end

  // The read in progress is number cnt_r+1.
  assign exhausted = (cnt_r >= CNT_W'(POLL_MAX - 1));
  assign gap_done  = (gap_r == '0);

endmodule

// File: rtl/alut_apb_master6.sv
// APB2 initiator for the ALUT register bank with valid/ready request and response ports.
// Status polling is built only when ALUT_APB_POLL_EN is defined.
module alut_apb_master6
  import alut_apb_master6_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 16,
  parameter int POLL_GAP = 2
) (
  input  logic              pclk6,
  input  logic              p_reset6,
  input  logic              req_valid6,
  output logic              req_ready6,
  input  logic              req_write6,
  input  logic              req_poll6,
  input  logic [ADDR_W-1:0] req_addr6,
  input  logic [DATA_W-1:0] req_wdata6,
  input  logic [DATA_W-1:0] req_mask6,
  output logic              rsp_valid6,
  input  logic              rsp_ready6,
  output logic [DATA_W-1:0] rsp_rdata6,
  output logic              rsp_timeout6,
  output logic              psel6,
  output logic              penable6,
  output logic              pwrite6,
  output logic [ADDR_W-1:0] paddr6,
  output logic [DATA_W-1:0] pwdata6,
  input  logic [DATA_W-1:0] prdata6
);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              write_r, write_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic              timeout_s;
  logic              accept_s;
  logic              apb_s;

  assign accept_s = req_valid6 & req_ready6;
  assign apb_s    = is_apb_state(state_s);

`ifdef ALUT_APB_POLL_EN
  logic [DATA_W-1:0] mask_r, mask_s;
  logic              poll_r, poll_s;
  logic              again_s, cnt_load_s, rd_tick_s, gap_load_s, gap_tick_s;
  logic              gap_done_s, exhausted_s;

  alut_poll_ctr6 #(.POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) u_poll_ctr6 (
    .pclk6     (pclk6),
    .p_reset6  (p_reset6),
    .load      (cnt_load_s),
    .tick      (rd_tick_s),
    .gap_load  (gap_load_s),
    .gap_tick  (gap_tick_s),
    .gap_done  (gap_done_s),
    .exhausted (exhausted_s)
  );
`else
  logic unused_poll_s;
  assign unused_poll_s = ^{req_poll6, req_mask6};
`endif

  // Next-state and request capture.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    write_s   = write_r;
    wdata_s   = wdata_r;
    timeout_s = 1'b0;
`ifdef ALUT_APB_POLL_EN
    mask_s     = mask_r;
    poll_s     = poll_r;
    again_s    = 1'b0;
    cnt_load_s = 1'b0;
    rd_tick_s  = 1'b0;
    gap_load_s = 1'b0;
    gap_tick_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SETUP;
          addr_s  = req_addr6;
          write_s = req_write6;
          wdata_s = req_write6 ? req_wdata6 : '0;
`ifdef ALUT_APB_POLL_EN
          mask_s     = req_mask6;
          poll_s     = req_poll6 & ~req_write6;
          cnt_load_s = 1'b1;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: state_s = ST_ACCESS;
      ST_ACCESS: begin
`ifdef ALUT_APB_POLL_EN
        rd_tick_s = 1'b1;
        again_s   = poll_r && ((prdata6 & mask_r) != '0);
        if (again_s && !exhausted_s) begin
          if (POLL_GAP > 0) begin
            state_s    = ST_WAIT;
            gap_load_s = 1'b1;
          end else begin
            state_s = ST_SETUP;
          end
        end else begin
          state_s   = ST_RESP;
          timeout_s = again_s;
        end
`else
        state_s = ST_RESP;
`endif
      end
      ST_WAIT: begin
`ifdef ALUT_APB_POLL_EN
        if (gap_done_s) begin
          state_s = ST_SETUP;
        end else begin
          gap_tick_s = 1'b1;
        end
`else
        state_s = ST_SETUP;
`endif
      end
      ST_RESP: begin
        if (rsp_ready6) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, captured request and registered bus/response outputs.
  always_ff @(posedge pclk6) begin
    if (p_reset6) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      write_r      <= 1'b0;
      wdata_r      <= '0;
      req_ready6   <= 1'b0;
      psel6        <= 1'b0;
      penable6     <= 1'b0;
      pwrite6      <= 1'b0;
      paddr6       <= '0;
      pwdata6      <= '0;
      rsp_valid6   <= 1'b0;
      rsp_rdata6   <= '0;
      rsp_timeout6 <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      write_r    <= write_s;
      wdata_r    <= wdata_s;
      req_ready6 <= (state_s == ST_IDLE);
      psel6      <= apb_s;
      penable6   <= (state_s == ST_ACCESS);
      pwrite6    <= apb_s ? write_s : 1'b0;
      paddr6     <= apb_s ? addr_s : '0;
      pwdata6    <= apb_s ? wdata_s : '0;
      if ((state_r == ST_ACCESS) && (state_s == ST_RESP)) begin
        rsp_valid6   <= 1'b1;
        rsp_rdata6   <= write_r ? '0 : prdata6;
        rsp_timeout6 <= timeout_s;
      end else if (state_s != ST_RESP) begin
        rsp_valid6   <= 1'b0;
        rsp_rdata6   <= '0;
        rsp_timeout6 <= 1'b0;
      end else begin
        rsp_valid6   <= rsp_valid6;
        rsp_rdata6   <= rsp_rdata6;
        rsp_timeout6 <= rsp_timeout6;
      end
    end
  end

`ifdef ALUT_APB_POLL_EN
  always_ff @(posedge pclk6) begin
    if (p_reset6) begin
      mask_r <= '0;
      poll_r <= 1'b0;
    end else begin
      mask_r <= mask_s;
      poll_r <= poll_s;
    end
  end
`endif

endmodule

// File: tb/tb_alut_apb_master6.sv
// Directed self-checking bench for alut_apb_master6 with a response scoreboard and APB slave model.
module tb_alut_apb_master6;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int POLL_MAX = 16;
  localparam int POLL_GAP = 2;
`ifdef ALUT_APB_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif
  localparam int          P5_N    = POLL_EN ? 3 : 1;
  localparam logic [31:0] P5_DATA = POLL_EN ? 32'h0 : 32'h1;
  localparam int          P6_N    = POLL_EN ? POLL_MAX : 1;
  localparam int          RST_ACC = POLL_EN ? 2 : 1;

  logic              pclk6 = 1'b0;
  logic              p_reset6 = 1'b0;
  logic              req_valid6 = 1'b0, req_ready6;
  logic              req_write6 = 1'b0, req_poll6 = 1'b0;
  logic [ADDR_W-1:0] req_addr6 = '0;
  logic [DATA_W-1:0] req_wdata6 = '0, req_mask6 = '0;
  logic              rsp_valid6, rsp_ready6 = 1'b0, rsp_timeout6;
  logic [DATA_W-1:0] rsp_rdata6;
  logic              psel6, penable6, pwrite6;
  logic [ADDR_W-1:0] paddr6;
  logic [DATA_W-1:0] pwdata6;
  logic [DATA_W-1:0] prdata6 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [31:0] slave_q[$];
  logic [31:0] slave_dflt = 32'h0;
  logic [32:0] exp_q[$];
  int setup_q[$];

  alut_apb_master6 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
    .pclk6(pclk6), .p_reset6(p_reset6),
    .req_valid6(req_valid6), .req_ready6(req_ready6), .req_write6(req_write6), .req_poll6(req_poll6),
    .req_addr6(req_addr6), .req_wdata6(req_wdata6), .req_mask6(req_mask6),
    .rsp_valid6(rsp_valid6), .rsp_ready6(rsp_ready6), .rsp_rdata6(rsp_rdata6), .rsp_timeout6(rsp_timeout6),
    .psel6(psel6), .penable6(penable6), .pwrite6(pwrite6), .paddr6(paddr6), .pwdata6(pwdata6),
    .prdata6(prdata6)
  );

  always #5 pclk6 = ~pclk6;

  always @(posedge pclk6) cyc <= cyc + 1;

  // Slave registers read data in SETUP so it is valid during ACCESS.
  always @(posedge pclk6) begin
    if (psel6 && !penable6 && !pwrite6) begin
      if (slave_q.size() > 0) prdata6 <= slave_q.pop_front();
      else prdata6 <= slave_dflt;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-protocol monitor and SETUP time log.
  always @(negedge pclk6) begin
    if (mon_en) begin
      if (!psel6) chk("idle_bus_zero", {penable6, pwrite6, paddr6, pwdata6}, 64'h0);
      if (psel6 && !pwrite6) chk("rd_pwdata_zero", pwdata6, 64'h0);
      if (psel6 && !penable6) setup_q.push_back(cyc);
    end
  end

  task automatic send(input logic w, input logic p, input logic [6:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic [31:0] er, input logic et);
    @(negedge pclk6);
    chk("req_ready_idle", req_ready6, 64'h1);
    req_write6 = w; req_poll6 = p; req_addr6 = a; req_wdata6 = d; req_mask6 = m;
    req_valid6 = 1'b1;
    exp_q.push_back({et, er});
    @(posedge pclk6); #1;
    req_valid6 = 1'b0; req_write6 = 1'b0; req_poll6 = 1'b0;
    req_addr6 = '0; req_wdata6 = '0; req_mask6 = '0;
  endtask

  task automatic wait_rsp(input int max_cyc);
    logic [32:0] e;
    int n = 0;
    @(negedge pclk6);
    while (rsp_valid6 !== 1'b1 && n < max_cyc) begin
      @(negedge pclk6);
      n++;
    end
    if (rsp_valid6 !== 1'b1) begin
      chk("rsp_wait_bound", rsp_valid6, 64'h1);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata6, e[31:0]);
      chk("rsp_timeout", rsp_timeout6, e[32]);
    end
    rsp_ready6 = 1'b1;
    @(posedge pclk6); #1;
    rsp_ready6 = 1'b0;
  endtask

  initial begin
    int n_acc;
    int k;
    // 1: reset
    p_reset6 = 1'b1;
    repeat (3) @(posedge pclk6);
    @(negedge pclk6);
    chk("rst_ctrl", {req_ready6, rsp_valid6, rsp_timeout6, psel6, penable6, pwrite6}, 64'h0);
    chk("rst_paddr", paddr6, 64'h0);
    chk("rst_pwdata", pwdata6, 64'h0);
    chk("rst_rdata", rsp_rdata6, 64'h0);
    mon_en = 1'b1;
    @(posedge pclk6); #1;
    p_reset6 = 1'b0;
    @(posedge pclk6); #1;

    // 2: write
    send(1'b1, 1'b0, 7'h0C, 32'hA5A5_0001, 32'h0, 32'h0, 1'b0);
    @(negedge pclk6);
    chk("wr_setup", {psel6, penable6, pwrite6}, 64'h5);
    chk("wr_paddr", paddr6, 64'h0C);
    chk("wr_pwdata", pwdata6, 64'hA5A5_0001);
    chk("wr_setup_noready", req_ready6, 64'h0);
    @(negedge pclk6);
    chk("wr_access", {psel6, penable6, pwrite6}, 64'h7);
    chk("wr_access_paddr", paddr6, 64'h0C);
    wait_rsp(0);

    // 3 + 4: read with response backpressure
    slave_q.push_back(32'h0000_0055);
    send(1'b0, 1'b0, 7'h2C, 32'hFFFF_FFFF, 32'h0, 32'h55, 1'b0);
    @(negedge pclk6);
    chk("rd_setup", {psel6, penable6, pwrite6}, 64'h4);
    chk("rd_paddr", paddr6, 64'h2C);
    @(negedge pclk6);
    chk("rd_access", {psel6, penable6, pwrite6}, 64'h6);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk6);
      chk("bp_hold", {rsp_valid6, req_ready6, psel6, penable6}, 64'h8);
      chk("bp_rdata", rsp_rdata6, 64'h55);
    end
    wait_rsp(0);

    // 5: poll clearing on the third read
    setup_q.delete();
    slave_q.push_back(32'h1); slave_q.push_back(32'h1); slave_q.push_back(32'h0);
    send(1'b0, 1'b1, 7'h2C, 32'h0, 32'h1, P5_DATA, 1'b0);
    wait_rsp(60);
    chk("p5_xfers", setup_q.size(), P5_N);
`ifdef ALUT_APB_POLL_EN
    chk("p5_gap1", setup_q[1] - setup_q[0], 64'd4);
    chk("p5_gap2", setup_q[2] - setup_q[1], 64'd4);
`endif
    slave_q.delete();

    // 6: poll that never clears, then reset during a later ACCESS
    setup_q.delete();
    slave_dflt = 32'h1;
    send(1'b0, 1'b1, 7'h2C, 32'h0, 32'h1, 32'h1, POLL_EN);
    wait_rsp(200);
    chk("p6_xfers", setup_q.size(), P6_N);

    send(1'b0, 1'b1, 7'h2C, 32'h0, 32'h1, 32'h1, POLL_EN);
    n_acc = 0;
    k = 0;
    while (n_acc < RST_ACC && k < 100) begin
      @(negedge pclk6);
      k++;
      if (psel6 && penable6) n_acc++;
    end
    chk("rst_acc_reached", n_acc, RST_ACC);
    p_reset6 = 1'b1;
    @(negedge pclk6);
    chk("rst_mid_bus", {psel6, penable6, rsp_valid6}, 64'h0);
    void'(exp_q.pop_back());
    @(posedge pclk6); #1;
    p_reset6 = 1'b0;
    slave_dflt = 32'h0;
    repeat (6) begin
      @(negedge pclk6);
      chk("rst_mid_norsp", rsp_valid6, 64'h0);
    end
    chk("rst_mid_ready", req_ready6, 64'h1);
    chk("sb_empty", exp_q.size(), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
